rf_wb_arbiter: RTL and testbench

Write-back arbiter and hazard scoreboard for the RV32I register file. Shares the register file's single write port between two producers, the ALU and the load/store unit, using valid/ready handshakes and round-robin arbitration. It also tracks which registers have writes in flight and stalls the issue stage on RAW and WAW hazards. It sits between execute/memory and the register file, and drives the register file's `rd_addr`/`w_val` directly.

---
 rtl/rf_pkg.sv | 20 ++
 rtl/rf_scoreboard.sv | 67 ++++++
 rtl/rf_wb_arbiter.sv | 92 +++++++++
 tb/tb_rf_wb_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and sizes for the RV32I register-file write-back slice.
package rf_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 32;

  // Which producer won the most recent write-back grant.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } wb_req_t;

  // One write-back request: destination register and data.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_s;

endpackage

// File: rtl/rf_scoreboard.sv
// Register write-pending scoreboard with issue-stall and forward-hit logic.
// Optional feature: define RF_WB_BYPASS_EN to let a source register that is
// being written this cycle bypass the stall and take rf_w_val instead.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [REG_AW-1:0] iss_rs1,
  input  logic [REG_AW-1:0] iss_rs2,
  input  logic [REG_AW-1:0] clr_addr,
  output logic [NREGS-1:0]  busy,
  output logic              iss_stall,
  output logic              fwd_rs1_hit,
  output logic              fwd_rs2_hit
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             set_en;

  // Forward hits: the register being committed this cycle matches a source.
`ifdef RF_WB_BYPASS_EN
  always_comb begin
    fwd_rs1_hit = (clr_addr == iss_rs1) && (clr_addr != '0);
    fwd_rs2_hit = (clr_addr == iss_rs2) && (clr_addr != '0);
  end
`else
  always_comb begin
    fwd_rs1_hit = 1'b0;
    fwd_rs2_hit = 1'b0;
  end
`endif

  // Stall on RAW (unless forwarded) or WAW against any pending write.
  always_comb begin
    iss_stall = iss_valid &&
                ((busy_q[iss_rs1] && !fwd_rs1_hit) ||
                 (busy_q[iss_rs2] && !fwd_rs2_hit) ||
                 busy_q[iss_rd]);
    set_en    = iss_valid && !iss_stall && (iss_rd != '0);
  end

  // Next busy vector: commit clears first so a same-register set wins.
  always_comb begin
    busy_d           = busy_q;
    busy_d[clr_addr] = 1'b0;
    if (set_en) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0]        = 1'b0;
  end

  // Busy state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: round-robin
// between ALU and LSU, registered write port, and the hazard scoreboard.
// Optional feature: RF_WB_BYPASS_EN (handled inside rf_scoreboard).
module rf_wb_arbiter
  import rf_pkg::REG_AW, rf_pkg::NREGS, rf_pkg::wb_req_t,
         rf_pkg::REQ_ALU, rf_pkg::REQ_LSU;
#(
  parameter int unsigned XLEN    = 32,
  parameter logic        RR_INIT = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [REG_AW-1:0] iss_rs1,
  input  logic [REG_AW-1:0] iss_rs2,
  output logic              iss_stall,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              lsu_ready,
  output logic [REG_AW-1:0] rf_rd_addr,
  output logic [XLEN-1:0]   rf_w_val,
  output logic [NREGS-1:0]  busy,
  output logic              fwd_rs1_hit,
  output logic              fwd_rs2_hit
);

  wb_req_t           last_grant_q;
  wb_req_t           last_grant_d;
  logic [REG_AW-1:0] rd_q;
  logic [REG_AW-1:0] rd_d;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   wdata_d;

  // Ready depends only on the valids and who won last, never on ready.
  always_comb begin
    alu_ready = alu_valid && (!lsu_valid || (last_grant_q == REQ_LSU));
    lsu_ready = lsu_valid && (!alu_valid || (last_grant_q == REQ_ALU));
  end

  // Select the granted request; no grant drives a no-op write to x0.
  always_comb begin
    last_grant_d = last_grant_q;
    rd_d         = '0;
    wdata_d      = '0;
    if (alu_ready) begin
      last_grant_d = REQ_ALU;
      rd_d         = alu_rd;
      wdata_d      = alu_data;
    end else if (lsu_ready) begin
      last_grant_d = REQ_LSU;
      rd_d         = lsu_rd;
      wdata_d      = lsu_data;
    end
  end

  // Round-robin pointer and register-file write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= wb_req_t'(RR_INIT);
      rd_q         <= '0;
      wdata_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_q         <= rd_d;
      wdata_q      <= wdata_d;
    end
  end

  assign rf_rd_addr = rd_q;
  assign rf_w_val   = wdata_q;

  rf_scoreboard u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .iss_valid   (iss_valid),
    .iss_rd      (iss_rd),
    .iss_rs1     (iss_rs1),
    .iss_rs2     (iss_rs2),
    .clr_addr    (rd_q),
    .busy        (busy),
    .iss_stall   (iss_stall),
    .fwd_rs1_hit (fwd_rs1_hit),
    .fwd_rs2_hit (fwd_rs2_hit)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed test-plan sequences then random traffic,
// checked against a reference model; write-port results go through a queue.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam logic RR_INIT_TB = 1'b1;

  logic        clock;
  logic        reset;
  logic        iss_valid;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2;
  logic        iss_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_w_val;
  logic [31:0] busy;
  logic        fwd_rs1_hit, fwd_rs2_hit;

  rf_wb_arbiter #(.XLEN(32), .RR_INIT(RR_INIT_TB)) dut (
    .clock(clock), .reset(reset),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_stall(iss_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_rd_addr(rf_rd_addr), .rf_w_val(rf_w_val), .busy(busy),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  wb_req_s exp_q[$];
  bit      mon_en = 1'b0;
  bit      chk_en = 1'b0;

  // Reference model state.
  bit         pending[32];    // register has a tracked write in flight
  int         favoured;       // 0: ALU wins a tie, 1: LSU wins a tie
  logic [4:0] port_addr_m;    // address the model says is on the port now
  bit         got_alu, got_lsu, iss_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: check combinational/state outputs, advance the model.
  task automatic cycle();
    int         winner;
    bit         e_f1, e_f2, e_st;
    logic [31:0] bexp;
    wb_req_s    nxt;
    @(negedge clock);
    winner = -1;
    if (alu_valid && lsu_valid) winner = favoured;
    else if (alu_valid)         winner = 0;
    else if (lsu_valid)         winner = 1;
`ifdef RF_WB_BYPASS_EN
    e_f1 = (port_addr_m != 5'd0) && (port_addr_m == iss_rs1);
    e_f2 = (port_addr_m != 5'd0) && (port_addr_m == iss_rs2);
`else
    e_f1 = 1'b0;
    e_f2 = 1'b0;
`endif
    e_st = iss_valid && ((pending[iss_rs1] && !e_f1) ||
                         (pending[iss_rs2] && !e_f2) || pending[iss_rd]);
    bexp = '0;
    for (int unsigned r = 0; r < 32; r++) bexp[r] = pending[r];
    if (chk_en) begin
      check("alu_ready",   32'(alu_ready),   32'(winner == 0));
      check("lsu_ready",   32'(lsu_ready),   32'(winner == 1));
      check("iss_stall",   32'(iss_stall),   32'(e_st));
      check("fwd_rs1_hit", 32'(fwd_rs1_hit), 32'(e_f1));
      check("fwd_rs2_hit", 32'(fwd_rs2_hit), 32'(e_f2));
      check("busy",        busy,             bexp);
    end
    got_alu = (winner == 0) && !reset;
    got_lsu = (winner == 1) && !reset;
    iss_acc = iss_valid && !e_st && !reset;
    nxt = '0;
    if (reset) begin
      for (int unsigned r = 0; r < 32; r++) pending[r] = 1'b0;
      favoured = RR_INIT_TB ? 0 : 1;
    end else begin
      if (port_addr_m != 5'd0) pending[port_addr_m] = 1'b0;
      if (iss_acc && iss_rd != 5'd0) pending[iss_rd] = 1'b1;
      if (winner == 0) begin
        nxt.rd = alu_rd; nxt.data = alu_data; favoured = 1;
      end else if (winner == 1) begin
        nxt.rd = lsu_rd; nxt.data = lsu_data; favoured = 0;
      end
    end
    exp_q.push_back(nxt);
    port_addr_m = nxt.rd;
    @(posedge clock);
    #1;
    mon_en = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic drive(input bit iv, input int ird, input int irs1, input int irs2,
                       input bit av, input int ard, input logic [31:0] ad,
                       input bit lv, input int lrd, input logic [31:0] ld);
    iss_valid = iv; iss_rd = 5'(ird); iss_rs1 = 5'(irs1); iss_rs2 = 5'(irs2);
    alu_valid = av; alu_rd = 5'(ard); alu_data = ad;
    lsu_valid = lv; lsu_rd = 5'(lrd); lsu_data = ld;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Write-port monitor: every presented cycle consumes one expected entry.
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en) begin
        wb_req_s e;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wb_port: got addr %0d with nothing expected", rf_rd_addr);
        end else begin
          e = exp_q.pop_front();
          check("rf_rd_addr", 32'(rf_rd_addr), 32'(e.rd));
          check("rf_w_val",   rf_w_val,        e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ap, lp, ip, rst_now;
    logic [4:0] ard, lrd, ird, irs1, irs2;
    logic [31:0] ad, ld;
    int         inflight[$];
    int         idx;

    for (int unsigned r = 0; r < 32; r++) pending[r] = 1'b0;
    favoured    = 0;
    port_addr_m = 5'd0;
    reset       = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    reset = 1'b0;

    // Conflict right after reset: ALU first, then LSU, then idle.
    drive(0, 0, 0, 0, 1, 1, 32'h11, 1, 2, 32'h22);
    cycle();
    cycle();
    idle(2);

    // Single ALU write to a tracked register.
    drive(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    cycle();
    idle(3);

    // RAW: x7 pending, dependent issue held across the write-back.
    drive(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(1, 0, 7, 0, 1, 7, 32'hCAFE0007, 0, 0, 0);
    cycle();
    drive(1, 0, 7, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();
    idle(1);

    // WAW on x3, then drain x3 through the LSU; x0 never stalls or tracks.
    drive(1, 3, 1, 2, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 3, 32'h33333333);
    cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    idle(3);

    // Untracked LSU write to x4, and an accepted write-back to x0.
    drive(0, 0, 0, 0, 1, 0, 32'h12345678, 1, 4, 32'h44444444);
    cycle();
    cycle();
    idle(2);

    // Reset while a granted x9 write is on the port.
    drive(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 1, 9, 32'h99999999, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle(2);

    // Random traffic with held-until-accepted producers and issue stage.
    ap = 0; lp = 0; ip = 0;
    ard = '0; lrd = '0; ird = '0; irs1 = '0; irs2 = '0; ad = '0; ld = '0;
    for (int c = 0; c < 3000; c++) begin
      rst_now = ($urandom_range(0, 199) == 0);
      if (!ap && $urandom_range(0, 2) == 0) begin
        ap = 1;
        if (inflight.size() > 0 && $urandom_range(0, 3) != 0) begin
          idx = int'($urandom_range(0, inflight.size() - 1));
          ard = 5'(inflight[idx]);
          inflight.delete(idx);
        end else begin
          ard = 5'($urandom_range(0, 7));
        end
        ad = $urandom;
      end
      if (!lp && $urandom_range(0, 2) == 0) begin
        lp = 1;
        if (inflight.size() > 0 && $urandom_range(0, 3) != 0) begin
          idx = int'($urandom_range(0, inflight.size() - 1));
          lrd = 5'(inflight[idx]);
          inflight.delete(idx);
        end else begin
          lrd = 5'($urandom_range(0, 7));
        end
        ld = $urandom;
      end
      if (!ip && $urandom_range(0, 1) == 0) begin
        ip   = 1;
        ird  = 5'($urandom_range(0, 7));
        irs1 = 5'($urandom_range(0, 7));
        irs2 = 5'($urandom_range(0, 7));
      end
      reset = rst_now;
      drive(ip && !rst_now, ird, irs1, irs2,
            ap && !rst_now, ard, ad, lp && !rst_now, lrd, ld);
      cycle();
      if (rst_now) begin
        ap = 0; lp = 0; ip = 0;
        inflight.delete();
      end else begin
        if (got_alu) ap = 0;
        if (got_lsu) lp = 0;
        if (iss_acc) begin
          ip = 0;
          if (ird != 5'd0) inflight.push_back(int'(ird));
        end
      end
    end
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clock);
    #1;
    mon_en = 1'b0;
    check("wb_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
